// File: rtl/clkrst_pkg.sv
// clkrst_pkg: shared definitions for the clock/reset power-up sequencer.
// Holds the 3-bit state encoding, default timing constants and a small
// saturating-increment helper for the retry counter.
package clkrst_pkg;

  localparam int STATE_W = 3;

  // State encoding, also exported on seq_state for debug/status
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_PLL_RST   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [STATE_W-1:0] ST_REL_M     = 3'd3;
  localparam logic [STATE_W-1:0] ST_REL_CAM   = 3'd4;
  localparam logic [STATE_W-1:0] ST_REL_P     = 3'd5;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd6;
  localparam logic [STATE_W-1:0] ST_FAIL      = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = ST_IDLE,
    S_PLL_RST   = ST_PLL_RST,
    S_WAIT_LOCK = ST_WAIT_LOCK,
    S_REL_M     = ST_REL_M,
    S_REL_CAM   = ST_REL_CAM,
    S_REL_P     = ST_REL_P,
    S_RUN       = ST_RUN,
    S_FAIL      = ST_FAIL
  } state_t;

  // Default timing constants (cycles of the reference clock)
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_RST_HOLD     = 16;
  localparam int DEF_LOCK_TIMEOUT = 4000;
  localparam int DEF_LOCK_STABLE  = 64;
  localparam int DEF_STAGGER      = 8;
  localparam int DEF_RETRY_MAX    = 3;

  // Retry counter increment that sticks at its maximum value
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/sync2_lvl.sv
// sync2_lvl: generic two-flop level synchronizer with asynchronous
// active-high reset. Outputs clear to 0 on reset; adds two cycles of latency.
module sync2_lvl #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // Two-stage capture of the asynchronous level into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/clkrst_seq.sv
// clkrst_seq: power-up / recovery sequencer for the board clock-reset tree.
// Holds the PLL in reset, waits for a stable lock (with timeout and retry),
// then releases the mclk, camera and pixel domain resets in turn.
// Build option LOCKLOSS_RECOVER_EN: when defined, a lock loss in RUN restarts
// the sequence; when undefined, RUN ignores lock loss and reports it on the
// sticky lock_lost output instead.
// All outputs are registered and computed from the next state.
module clkrst_seq
  import clkrst_pkg::*;
#(
  parameter int RST_HOLD     = DEF_RST_HOLD,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int STAGGER      = DEF_STAGGER,
  parameter int RETRY_MAX    = DEF_RETRY_MAX,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       sw_rst_req,
  output logic       pll_rst,
  output logic       rst_m_n,
  output logic       rst_cam_n,
  output logic       rst_p_n,
  output logic       seq_done,
  output logic       seq_fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] seq_state
`ifndef LOCKLOSS_RECOVER_EN
  ,
  output logic       lock_lost
`endif
);

  // Terminal counts: a phase of N cycles ends when the counter reads N-1
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
  localparam logic [1:0]       RETRY_LIM    = 2'(RETRY_MAX);

  logic             lock_s;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] stable_reg, stable_next;
  logic [1:0]       retry_reg, retry_next;
  logic             restart;
  logic             fail_attempt;
  logic             pll_rst_reg, pll_rst_next;
  logic             rst_m_n_reg, rst_m_n_next;
  logic             rst_cam_n_reg, rst_cam_n_next;
  logic             rst_p_n_reg, rst_p_n_next;
  logic             done_reg, done_next;
  logic             fail_reg, fail_next;
`ifndef LOCKLOSS_RECOVER_EN
  logic             lost_reg, lost_next;
`endif

  sync2_lvl #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state, retry, counters and registered-output values
  always_comb begin
    state_next   = state_reg;
    retry_next   = retry_reg;
    restart      = 1'b0;
    fail_attempt = 1'b0;

    if (sw_rst_req && (state_reg != S_IDLE)) begin
      // Software restart wins over timeout and lock loss
      state_next = S_PLL_RST;
      retry_next = 2'd0;
      restart    = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE:      state_next = S_PLL_RST;
        S_PLL_RST:   if (cnt_reg == HOLD_LAST) state_next = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          // A stable lock completing on the timeout cycle still counts as success
          if (lock_s && (stable_reg == STABLE_LAST)) state_next = S_REL_M;
          else if (cnt_reg == TIMEOUT_LAST)          fail_attempt = 1'b1;
        end
        S_REL_M: begin
          if (!lock_s)                       fail_attempt = 1'b1;
          else if (cnt_reg == STAGGER_LAST)  state_next = S_REL_CAM;
        end
        S_REL_CAM: begin
          if (!lock_s)                       fail_attempt = 1'b1;
          else if (cnt_reg == STAGGER_LAST)  state_next = S_REL_P;
        end
        S_REL_P: begin
          if (!lock_s) fail_attempt = 1'b1;
          else         state_next = S_RUN;
        end
        S_RUN: begin
`ifdef LOCKLOSS_RECOVER_EN
          // Lock loss while running starts a fresh sequence
          if (!lock_s) begin
            state_next = S_PLL_RST;
            retry_next = 2'd0;
          end
`endif
        end
        S_FAIL:  state_next = S_FAIL;
        default: state_next = S_IDLE;
      endcase

      if (fail_attempt) begin
        retry_next = sat_inc2(retry_reg);
        state_next = (retry_next == RETRY_LIM) ? S_FAIL : S_PLL_RST;
      end
    end

    // A restart from PLL_RST re-enters the same state, so it also clears the counter
    cnt_next    = ((state_next != state_reg) || restart) ? '0 : cnt_reg + 1'b1;
    stable_next = ((state_reg == S_WAIT_LOCK) && lock_s) ? stable_reg + 1'b1 : '0;

    pll_rst_next   = (state_next == S_IDLE) || (state_next == S_PLL_RST) ||
                     (state_next == S_FAIL);
    rst_m_n_next   = (state_next == S_REL_M) || (state_next == S_REL_CAM) ||
                     (state_next == S_REL_P) || (state_next == S_RUN);
    rst_cam_n_next = (state_next == S_REL_CAM) || (state_next == S_REL_P) ||
                     (state_next == S_RUN);
    rst_p_n_next   = (state_next == S_REL_P) || (state_next == S_RUN);
    done_next      = (state_next == S_RUN);
    fail_next      = (state_next == S_FAIL);
`ifndef LOCKLOSS_RECOVER_EN
    lost_next      = sw_rst_req ? 1'b0 : (lost_reg || ((state_reg == S_RUN) && !lock_s));
`endif
  end

  // State, counters and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      stable_reg    <= '0;
      retry_reg     <= 2'd0;
      pll_rst_reg   <= 1'b1;
      rst_m_n_reg   <= 1'b0;
      rst_cam_n_reg <= 1'b0;
      rst_p_n_reg   <= 1'b0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      stable_reg    <= stable_next;
      retry_reg     <= retry_next;
      pll_rst_reg   <= pll_rst_next;
      rst_m_n_reg   <= rst_m_n_next;
      rst_cam_n_reg <= rst_cam_n_next;
      rst_p_n_reg   <= rst_p_n_next;
      done_reg      <= done_next;
      fail_reg      <= fail_next;
    end
  end

`ifndef LOCKLOSS_RECOVER_EN
  // Sticky record of a lock loss seen while running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lost_reg <= 1'b0;
    else       lost_reg <= lost_next;
  end

  assign lock_lost = lost_reg;
`endif

  assign pll_rst   = pll_rst_reg;
  assign rst_m_n   = rst_m_n_reg;
  assign rst_cam_n = rst_cam_n_reg;
  assign rst_p_n   = rst_p_n_reg;
  assign seq_done  = done_reg;
  assign seq_fail  = fail_reg;
  assign retry_cnt = retry_reg;
  assign seq_state = state_reg;

endmodule

// File: tb/tb_clkrst_seq.sv
// tb_clkrst_seq: directed self-checking bench for clkrst_seq.
// Instance a uses default timing, instance b uses LOCK_TIMEOUT=100.
// Cycle numbers count rising edges after reset release; outputs are sampled
// 1 time unit after each rising edge.
module tb_clkrst_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw_rst_req = 1'b0;
  logic lock_a = 1'b0;
  logic lock_b = 1'b0;

  logic       a_pll_rst, a_rst_m_n, a_rst_cam_n, a_rst_p_n, a_done, a_fail;
  logic [1:0] a_retry;
  logic [2:0] a_state;
  logic       b_pll_rst, b_rst_m_n, b_rst_cam_n, b_rst_p_n, b_done, b_fail;
  logic [1:0] b_retry;
  logic [2:0] b_state;
`ifndef LOCKLOSS_RECOVER_EN
  logic       a_lost, b_lost;
`endif

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  clkrst_seq dut_a (
    .clk(clk), .reset(reset), .pll_lock(lock_a), .sw_rst_req(sw_rst_req),
    .pll_rst(a_pll_rst), .rst_m_n(a_rst_m_n), .rst_cam_n(a_rst_cam_n),
    .rst_p_n(a_rst_p_n), .seq_done(a_done), .seq_fail(a_fail),
    .retry_cnt(a_retry), .seq_state(a_state)
`ifndef LOCKLOSS_RECOVER_EN
    , .lock_lost(a_lost)
`endif
  );

  clkrst_seq #(.LOCK_TIMEOUT(100)) dut_b (
    .clk(clk), .reset(reset), .pll_lock(lock_b), .sw_rst_req(sw_rst_req),
    .pll_rst(b_pll_rst), .rst_m_n(b_rst_m_n), .rst_cam_n(b_rst_cam_n),
    .rst_p_n(b_rst_p_n), .seq_done(b_done), .seq_fail(b_fail),
    .retry_cnt(b_retry), .seq_state(b_state)
`ifndef LOCKLOSS_RECOVER_EN
    , .lock_lost(b_lost)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sw_rst_req = 1'b0;
    lock_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse_sw();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (a_state !== 3'd0) begin failed++; $display("FAIL rst_state: got %0d want 0", a_state); end
    tests++; if ({a_pll_rst, a_rst_m_n, a_rst_cam_n, a_rst_p_n} !== 4'b1000) begin failed++; $display("FAIL rst_resets: got %b want 1000", {a_pll_rst, a_rst_m_n, a_rst_cam_n, a_rst_p_n}); end
    tests++; if ({a_done, a_fail, a_retry} !== 4'b0000) begin failed++; $display("FAIL rst_status: got %b want 0000", {a_done, a_fail, a_retry}); end
    tests++; if ({b_state, b_pll_rst, b_retry} !== 6'b000100) begin failed++; $display("FAIL rst_b: got %b want 000100", {b_state, b_pll_rst, b_retry}); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_nominal();
    apply_reset();
    tick();
    tests++; if (a_state !== 3'd1) begin failed++; $display("FAIL nom_pllrst_state: got %0d want 1", a_state); end
    tick_to(16);
    tests++; if (a_pll_rst !== 1'b1) begin failed++; $display("FAIL nom_pllrst_c16: got %b want 1", a_pll_rst); end
    tick();
    tests++; if ({a_pll_rst, a_state} !== {1'b0, 3'd2}) begin failed++; $display("FAIL nom_pllrst_fall: got %b/%0d want 0/2", a_pll_rst, a_state); end
    tick_to(100);
    lock_a = 1'b1;
    for (int i = 0; i < 300 && a_rst_m_n !== 1'b1; i++) tick();
    tests++; if (cyc !== 166 || a_state !== 3'd3) begin failed++; $display("FAIL nom_m_rise: got cyc %0d state %0d want 166 3", cyc, a_state); end
    for (int i = 0; i < 50 && a_rst_cam_n !== 1'b1; i++) tick();
    tests++; if (cyc !== 174 || a_rst_p_n !== 1'b0) begin failed++; $display("FAIL nom_cam_rise: got cyc %0d want 174", cyc); end
    for (int i = 0; i < 50 && a_rst_p_n !== 1'b1; i++) tick();
    tests++; if (cyc !== 182 || a_done !== 1'b0) begin failed++; $display("FAIL nom_p_rise: got cyc %0d want 182", cyc); end
    for (int i = 0; i < 50 && a_done !== 1'b1; i++) tick();
    tests++; if (cyc !== 183 || a_state !== 3'd6 || a_retry !== 2'd0) begin failed++; $display("FAIL nom_done: got cyc %0d state %0d retry %0d want 183 6 0", cyc, a_state, a_retry); end
    $display("[TB] test_nominal done");
  endtask

  task automatic test_timeout();
    lock_b = 1'b0;
    apply_reset();
    tick_to(116);
    tests++; if ({b_pll_rst, b_retry} !== 3'b000) begin failed++; $display("FAIL to_c116: got %b want 000", {b_pll_rst, b_retry}); end
    tick();
    tests++; if ({b_pll_rst, b_retry, b_state} !== {1'b1, 2'd1, 3'd1}) begin failed++; $display("FAIL to_retry1: got %b want 101001", {b_pll_rst, b_retry, b_state}); end
    tick_to(132);
    tests++; if (b_pll_rst !== 1'b1) begin failed++; $display("FAIL to_pulse2_end: got %b want 1", b_pll_rst); end
    tick();
    tests++; if ({b_pll_rst, b_state} !== {1'b0, 3'd2}) begin failed++; $display("FAIL to_wait2: got %b want 0010", {b_pll_rst, b_state}); end
    tick_to(233);
    tests++; if ({b_pll_rst, b_retry} !== 3'b110) begin failed++; $display("FAIL to_retry2: got %b want 110", {b_pll_rst, b_retry}); end
    tick_to(249);
    tests++; if (b_pll_rst !== 1'b0) begin failed++; $display("FAIL to_wait3: got %b want 0", b_pll_rst); end
    tick_to(348);
    tests++; if (b_fail !== 1'b0) begin failed++; $display("FAIL to_early_fail: got %b want 0", b_fail); end
    tick();
    tests++; if ({b_fail, b_state, b_retry, b_pll_rst} !== {1'b1, 3'd7, 2'd3, 1'b1}) begin failed++; $display("FAIL to_fail: got %b want 1111111", {b_fail, b_state, b_retry, b_pll_rst}); end
    tests++; if ({b_rst_m_n, b_rst_cam_n, b_rst_p_n, b_done} !== 4'b0000) begin failed++; $display("FAIL to_fail_resets: got %b want 0000", {b_rst_m_n, b_rst_cam_n, b_rst_p_n, b_done}); end
    tick_to(400);
    tests++; if (b_state !== 3'd7) begin failed++; $display("FAIL to_fail_sticky: got %0d want 7", b_state); end
    $display("[TB] test_timeout done");
  endtask

  task automatic test_sw_in_fail();
    int c0;
    c0 = cyc;
    lock_b = 1'b1;
    pulse_sw();
    tests++; if ({b_state, b_retry, b_fail, b_pll_rst} !== {3'd1, 2'd0, 1'b0, 1'b1}) begin failed++; $display("FAIL swf_restart: got %b want 0010001", {b_state, b_retry, b_fail, b_pll_rst}); end
    tests++; if ({b_rst_m_n, b_rst_cam_n, b_rst_p_n} !== 3'b000) begin failed++; $display("FAIL swf_resets: got %b want 000", {b_rst_m_n, b_rst_cam_n, b_rst_p_n}); end
    for (int i = 0; i < 300 && b_rst_m_n !== 1'b1; i++) tick();
    tests++; if (cyc - c0 !== 81) begin failed++; $display("FAIL swf_m_rise: got +%0d want +81", cyc - c0); end
    for (int i = 0; i < 100 && b_done !== 1'b1; i++) tick();
    tests++; if (cyc - c0 !== 98 || b_state !== 3'd6 || b_retry !== 2'd0) begin failed++; $display("FAIL swf_done: got +%0d state %0d want +98 6", cyc - c0, b_state); end
    $display("[TB] test_sw_in_fail done");
  endtask

  task automatic test_glitch();
    apply_reset();
    tick_to(20);
    lock_a = 1'b1;
    tick_to(60);
    lock_a = 1'b0;
    tick();
    lock_a = 1'b1;
    tick_to(126);
    tests++; if (a_rst_m_n !== 1'b0) begin failed++; $display("FAIL gl_early: got %b want 0", a_rst_m_n); end
    for (int i = 0; i < 100 && a_rst_m_n !== 1'b1; i++) tick();
    tests++; if (cyc !== 127 || a_retry !== 2'd0) begin failed++; $display("FAIL gl_release: got cyc %0d retry %0d want 127 0", cyc, a_retry); end
    $display("[TB] test_glitch done");
  endtask

  task automatic test_drop_relcam();
    apply_reset();
    tick_to(20);
    lock_a = 1'b1;
    tick_to(96);
    lock_a = 1'b0;
    tick_to(98);
    tests++; if ({a_state, a_rst_m_n, a_rst_cam_n} !== {3'd4, 2'b11}) begin failed++; $display("FAIL drop_before: got %b want 10011", {a_state, a_rst_m_n, a_rst_cam_n}); end
    tick();
    tests++; if ({a_rst_m_n, a_rst_cam_n, a_pll_rst} !== 3'b001) begin failed++; $display("FAIL drop_resets: got %b want 001", {a_rst_m_n, a_rst_cam_n, a_pll_rst}); end
    tests++; if (a_retry !== 2'd1 || a_state !== 3'd1) begin failed++; $display("FAIL drop_retry: got retry %0d state %0d want 1 1", a_retry, a_state); end
    $display("[TB] test_drop_relcam done");
  endtask

  task automatic test_sw_in_run();
    apply_reset();
    tick_to(20);
    lock_a = 1'b1;
    tick_to(110);
    tests++; if (a_done !== 1'b1) begin failed++; $display("FAIL swr_running: got %b want 1", a_done); end
    pulse_sw();
    tests++; if ({a_state, a_retry, a_done, a_pll_rst} !== {3'd1, 2'd0, 1'b0, 1'b1}) begin failed++; $display("FAIL swr_restart: got %b want 0010001", {a_state, a_retry, a_done, a_pll_rst}); end
    tests++; if ({a_rst_m_n, a_rst_cam_n, a_rst_p_n} !== 3'b000) begin failed++; $display("FAIL swr_resets: got %b want 000", {a_rst_m_n, a_rst_cam_n, a_rst_p_n}); end
    for (int i = 0; i < 300 && a_done !== 1'b1; i++) tick();
    tests++; if (cyc !== 208) begin failed++; $display("FAIL swr_done: got cyc %0d want 208", cyc); end
    $display("[TB] test_sw_in_run done");
  endtask

  task automatic test_lockloss_run();
    apply_reset();
    tick_to(20);
    lock_a = 1'b1;
    tick_to(110);
    lock_a = 1'b0;
    tick_to(112);
    tests++; if (a_state !== 3'd6) begin failed++; $display("FAIL ll_before: got %0d want 6", a_state); end
    tick();
`ifdef LOCKLOSS_RECOVER_EN
    tests++; if ({a_state, a_rst_m_n, a_rst_p_n, a_pll_rst, a_done} !== {3'd1, 4'b0010}) begin failed++; $display("FAIL ll_recover: got %b want 0010010", {a_state, a_rst_m_n, a_rst_p_n, a_pll_rst, a_done}); end
    tests++; if (a_retry !== 2'd0) begin failed++; $display("FAIL ll_retry: got %0d want 0", a_retry); end
`else
    tests++; if ({a_state, a_rst_m_n, a_rst_p_n, a_done, a_lost} !== {3'd6, 4'b1111}) begin failed++; $display("FAIL ll_ignore: got %b want 1101111", {a_state, a_rst_m_n, a_rst_p_n, a_done, a_lost}); end
    lock_a = 1'b1;
    tick_to(130);
    tests++; if (a_lost !== 1'b1 || a_rst_cam_n !== 1'b1) begin failed++; $display("FAIL ll_sticky: got %b%b want 11", a_lost, a_rst_cam_n); end
    pulse_sw();
    tests++; if (a_lost !== 1'b0 || a_state !== 3'd1) begin failed++; $display("FAIL ll_clear: got lost %b state %0d want 0 1", a_lost, a_state); end
`endif
    $display("[TB] test_lockloss_run done");
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick_to(20);
    lock_a = 1'b1;
    tick_to(90);
    tests++; if (a_rst_m_n !== 1'b1) begin failed++; $display("FAIL ar_before: got %b want 1", a_rst_m_n); end
    reset = 1'b1;
    #1;
    tests++; if ({a_state, a_pll_rst, a_rst_m_n, a_retry} !== {3'd0, 1'b1, 1'b0, 2'd0}) begin failed++; $display("FAIL ar_immediate: got %b want 00010", {a_state, a_pll_rst, a_rst_m_n, a_retry}); end
    tick();
    reset = 1'b0;
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_sw_in_fail();
    test_glitch();
    test_drop_relcam();
    test_sw_in_run();
    test_lockloss_run();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/clkrst_seq.md
Name: clkrst_seq

Overview:
Power-up and recovery sequencer for the board clock/reset tree. Runs on the free-running reference clock and drives the DCM/PLL reset. It waits for PLL lock with a timeout and retry, then releases the mclk, camera and pixel domain resets one after another. Its outputs feed the per-domain reset synchronizers; it never drives a destination-domain flop directly.

Parameters:
RST_HOLD, 16, cycles pll_rst is held high per attempt (min 1)
LOCK_TIMEOUT, 4000, max cycles in WAIT_LOCK before the attempt counts as failed
LOCK_STABLE, 64, consecutive cycles synced lock must stay high before release
STAGGER, 8, cycles between successive domain reset releases (min 1)
RETRY_MAX, 3, failed attempts allowed before entering FAIL
CNT_W, 16, width of the shared cycle counter; every timing parameter must be < 2^CNT_W

Ports:
clk  input  1  free-running reference clock; all logic is in this domain
reset  input  1  asynchronous, active-high reset
pll_lock  input  1  PLL LOCKED, asynchronous to clk
sw_rst_req  input  1  single-cycle restart request from the register block
pll_rst  output  1  PLL reset, active-high
rst_m_n  output  1  mclk-domain reset request, active-low
rst_cam_n  output  1  camera-domain reset request, active-low
rst_p_n  output  1  pixel-domain reset request, active-low
seq_done  output  1  high only in RUN
seq_fail  output  1  high only in FAIL
retry_cnt  output  2  failed attempts in the current sequence
seq_state  output  3  encoded state for debug/status

Behaviour:
- Reset values: state=IDLE, pll_rst=1, rst_m_n=rst_cam_n=rst_p_n=0, seq_done=0, seq_fail=0, retry_cnt=0, counter=0.
- pll_lock passes through a 2-flop synchronizer, giving lock_s. This adds 2 cycles of latency and is reset to 0.
- One shared counter. It clears on every state change and increments every cycle otherwise.
- States (seq_state encoding): IDLE=0, PLL_RST=1, WAIT_LOCK=2, REL_M=3, REL_CAM=4, REL_P=5, RUN=6, FAIL=7.
- IDLE: next cycle goes to PLL_RST unconditionally.
- PLL_RST: pll_rst=1. After RST_HOLD cycles, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0.
  - The stability count restarts whenever lock_s=0.
  - When lock_s has been high for LOCK_STABLE consecutive cycles, go to REL_M.
  - If LOCK_TIMEOUT cycles pass first, increment retry_cnt (saturating). If the new count equals RETRY_MAX, go to FAIL; otherwise go back to PLL_RST.
- REL_M: rst_m_n=1 on entry. After STAGGER cycles, go to REL_CAM.
- REL_CAM: rst_cam_n=1 on entry. After STAGGER cycles, go to REL_P.
- REL_P: rst_p_n=1 on entry. Next cycle go to RUN.
- Once a domain reset is released it stays released until the sequence restarts.
- RUN: seq_done=1 and all resets stay released. Lock loss is handled as described under Optional Feature.
- FAIL: seq_fail=1, pll_rst=1, all domain resets asserted. Leave FAIL only via sw_rst_req or reset.
- sw_rst_req in any state except IDLE:
  - Next cycle state=PLL_RST, retry_cnt=0.
  - All domain resets are asserted that same cycle, and pll_rst=1.
- Lock drop during REL_M, REL_CAM or REL_P: abort.
  - Assert all domain resets and go to PLL_RST.
  - This counts as a failed attempt (retry_cnt increment and RETRY_MAX check apply).
- Simultaneous events: sw_rst_req has priority over timeout and lock loss.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronously).
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
LOCKLOSS_RECOVER_EN.
- Defined: lock_s=0 in RUN asserts all domain resets the next cycle and goes to PLL_RST. retry_cnt is cleared, so this is a fresh sequence.
- Undefined: RUN ignores lock_s, and outputs stay released. A sticky status bit lock_lost (extra output port, present only in this build) sets on lock_s=0 in RUN and clears only on sw_rst_req or reset.

Decomposition:
- Package clkrst_pkg holds: the state encoding localparams (3-bit), the default timing constants, and the CNT_W default.
- One sub-module, sync2_lvl: a generic 2-flop level synchronizer with async active-high reset. It is used for pll_lock and is reusable elsewhere.
- Everything else is a single FSM plus the counter in clkrst_seq.

Test Plan:
- Nominal bring-up (defaults): pll_lock rises 100 cycles after reset deassert.
  - pll_rst falls at cycle 17.
  - rst_m_n rises 2+64 cycles after pll_lock rises (sync + LOCK_STABLE).
  - rst_cam_n follows 8 cycles later, rst_p_n 8 cycles after that.
  - seq_done=1 one cycle after rst_p_n.
- Lock never arrives (LOCK_TIMEOUT=100, RETRY_MAX=3): three PLL_RST pulses of 16 cycles each, retry_cnt steps 1, 2, 3, then seq_fail=1 and seq_state=7 with all domain resets low.
- Lock glitch: pll_lock high 40 cycles, low 1 cycle, then high → release occurs 64 stable cycles after the final rise; no timeout.
- Lock drop in REL_CAM: rst_m_n and rst_cam_n return to 0 the next cycle, pll_rst=1, retry_cnt=1.
- sw_rst_req in FAIL and in RUN: state goes to PLL_RST next cycle with retry_cnt=0 and all domain resets low, then the full nominal sequence completes.
- Lock loss in RUN:
  - With LOCKLOSS_RECOVER_EN: restarts at PLL_RST.
  - Without it: resets stay released and lock_lost=1 until sw_rst_req.
